store_rmw_unit: RTL and testbench
=================================

# store_rmw_unit

Store-path counterpart to the load extract/sign-extend logic in the RV32 core. Takes a store request (sb/sh/sw, byte address, rs2 data) from the execute stage and writes it to a word-only data memory with no byte enables. For sb/sh it reads the target word, merges the new byte or halfword into the correct lane, and writes the word back. Full words go straight to memory. Misaligned accesses and memory timeouts are reported as faults.

## Interface
- TIMEOUT, default 16: max cycles to wait for mem_ack per memory phase; range 2..255.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  unit idle, can accept a request; high only in IDLE.
- st_funct3  in  3  3'b000 sb, 3'b001 sh, 3'b010 sw; any other value is a fault.
- st_addr  in  32  byte address.
- st_data  in  32  rs2 value; low byte or halfword used for sb/sh.
- st_done  out  1  one-cycle pulse, store committed.
- st_fault  out  1  one-cycle pulse, store aborted (misaligned, illegal funct3 or timeout).
- mem_addr  out  32  word address, {addr[31:2], 2'b00}.
- mem_rd_en  out  1  read request, held until mem_ack.
- mem_wr_en  out  1  write request, held until mem_ack.
- mem_wdata  out  32  merged write word.
- mem_rdata  in  32  read data, valid in the mem_ack cycle.
- mem_ack  in  1  memory completes the current request.

## Operation
- States: IDLE, CHECK, READ, WRITE, DONE, FAULT.
- IDLE: st_ready=1. On st_valid, latch funct3, addr and data, then go to CHECK.
- CHECK:
  - Fault if funct3 is illegal, if sh has addr[0]=1, or if sw has addr[1:0]≠0. Fault goes to FAULT.
  - sw loads wdata=data and goes to WRITE.
  - sb/sh go to READ.
- READ: mem_rd_en=1. On mem_ack, merge into wdata and go to WRITE.
  - sb: lane addr[1:0] gets data[7:0].
  - sh: lane addr[1] gets data[15:0].
  - Other lanes keep mem_rdata.
- WRITE: mem_wr_en=1, mem_wdata=wdata. On mem_ack go to DONE.
- DONE: st_done=1 for one cycle, then IDLE.
- FAULT: st_fault=1 for one cycle, then IDLE. No memory request is issued for an alignment or funct3 fault.
- Timeout counter: cleared on entry to READ or WRITE, increments each cycle without mem_ack. When it reaches TIMEOUT-1 with no ack, drop the request and go to FAULT. An ack in that same cycle wins.
- mem_rd_en and mem_wr_en are never high together.
- mem_addr is stable for the whole READ and WRITE phases.

## Timing
- Reset values: state IDLE, st_ready=1, and 0 for st_done, st_fault, mem_rd_en, mem_wr_en, mem_addr, mem_wdata and the counter.
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- sw with a zero-wait ack (ack in the first WRITE cycle): accept in cycle 0, CHECK in cycle 1, WRITE in cycle 2, st_done in cycle 3. Next accept is in cycle 4.
- sb/sh with zero-wait acks: READ in cycle 2, WRITE in cycle 3, st_done in cycle 4.
- Each memory wait cycle adds one cycle to the latency.
- Alignment fault: st_fault in cycle 2.
- st_valid outside IDLE is ignored; the requester holds the request until it sees st_ready.
- mem_ack outside READ/WRITE is ignored.
- Reset mid-operation: return to IDLE immediately. No pending write is issued after reset. A partially completed RMW is dropped; memory keeps its old word.

## Structure
- Package store_pkg holds the FUNCT3_SB, FUNCT3_SH and FUNCT3_SW constants and the state enum.
- Sub-module store_lane_merge is purely combinational: inputs old word, new data, funct3, addr[1:0]; output merged word.
- The FSM, timeout counter and request latches live in the top module.

## Test plan
- sb addr 0x1003, data 0x000000AB, mem word 0x11223344 → read at 0x1000, then write 0xAB223344; st_done in cycle 4.
- sh addr 0x2002, data 0x0000BEEF, mem 0x11223344 → write 0xBEEF3344. sb addr 0x2001, data 0xCC → write 0x1122CC44.
- sw addr 0x3000, data 0xDEADBEEF with 2 wait cycles → no mem_rd_en; one write of 0xDEADBEEF; st_done in cycle 5.
- sh addr 0x2001, and sw addr 0x3002 → st_fault in cycle 2; mem_rd_en and mem_wr_en stay 0.
- TIMEOUT=4 with mem_ack held low during READ → st_fault after 4 READ cycles; no write; st_ready=1 the next cycle.
- rst_n asserted during WRITE → mem_wr_en=0 asynchronously; after release st_ready=1 and no spurious st_done.

Source files
------------

// File: rtl/store_pkg.sv
// Shared definitions for the store read-modify-write path.
package store_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    localparam logic [2:0] FUNCT3_SB = 3'b000;
    localparam logic [2:0] FUNCT3_SH = 3'b001;
    localparam logic [2:0] FUNCT3_SW = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    // Latched store request; only the byte offset of the address is kept,
    // the word part goes straight into the memory address register.
    typedef struct packed {
        logic [2:0]      funct3;
        logic [1:0]      addr_lo;
        logic [XLEN-1:0] data;
    } store_req_t;

    // Legal funct3 with natural alignment for its access size.
    function automatic logic is_legal(input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            FUNCT3_SB: ok = 1'b1;
            FUNCT3_SH: ok = ~addr_lo[0];
            FUNCT3_SW: ok = (addr_lo == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: drops a new byte/halfword/word into an old word.
//   old_word : word read back from memory
//   new_data : rs2 value (low byte/halfword used for sb/sh)
//   funct3   : store size
//   addr_lo  : byte offset within the word
//   merged_c : word to write back
module store_lane_merge
    import store_pkg::*;
(
    input  logic [XLEN-1:0] old_word,
    input  logic [XLEN-1:0] new_data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] merged_c
);

    always_comb begin
        merged_c = old_word;
        case (funct3)
            FUNCT3_SB: merged_c[{addr_lo, 3'b000} +: 8]     = new_data[7:0];
            FUNCT3_SH: merged_c[{addr_lo[1], 4'b0000} +: 16] = new_data[15:0];
            FUNCT3_SW: merged_c = new_data;
            default:   merged_c = old_word;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit for a word-only data memory: sb/sh become read-modify-write,
// sw is a single write. Misalignment, illegal funct3 and memory timeouts
// abort the store with a one-cycle st_fault pulse.
//   st_*  : request from execute (valid/ready), done/fault pulses
//   mem_* : word memory port, rd/wr requests held until mem_ack
module store_rmw_unit
    import store_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [2:0]      st_funct3,
    input  logic [XLEN-1:0] st_addr,
    input  logic [XLEN-1:0] st_data,
    output logic            st_done,
    output logic            st_fault,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_rd_en,
    output logic            mem_wr_en,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack
);

    state_e          state_q;
    state_e          state_d;
    store_req_t      req_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [XLEN-1:0] wdata_d;
    logic [XLEN-1:0] merged_c;
    logic            load_req;
    logic            legal_c;
    logic            timeout_c;

    assign legal_c   = is_legal(req_q.funct3, req_q.addr_lo);
    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Merge uses the read data directly; it is only consumed in the ack cycle.
    store_lane_merge u_merge (
        .old_word (mem_rdata),
        .new_data (req_q.data),
        .funct3   (req_q.funct3),
        .addr_lo  (req_q.addr_lo),
        .merged_c (merged_c)
    );

    // Next-state, timeout counter and write-data selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wdata_d  = mem_wdata;
        load_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (st_valid) begin
                    load_req = 1'b1;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                cnt_d = '0;
                if (!legal_c) begin
                    state_d = ST_FAULT;
                end else if (req_q.funct3 == FUNCT3_SW) begin
                    wdata_d = req_q.data;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (mem_ack) begin
                    wdata_d = merged_c;
                    cnt_d   = '0;
                    state_d = ST_WRITE;
                end else if (timeout_c) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                end else if (timeout_c) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, counter and request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_req) begin
                req_q.funct3  <= st_funct3;
                req_q.addr_lo <= st_addr[1:0];
                req_q.data    <= st_data;
            end
        end
    end

    // Outputs are registered copies of the next-state decode, so they line
    // up with the state and reset asynchronously with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_ready  <= 1'b1;
            st_done   <= 1'b0;
            st_fault  <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            st_ready  <= (state_d == ST_IDLE);
            st_done   <= (state_d == ST_DONE);
            st_fault  <= (state_d == ST_FAULT);
            mem_rd_en <= (state_d == ST_READ);
            mem_wr_en <= (state_d == ST_WRITE);
            mem_wdata <= wdata_d;
            if (load_req) begin
                mem_addr <= {st_addr[XLEN-1:2], 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
module tb_store_rmw_unit;
    import store_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [2:0]  st_funct3 = 3'b000;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_done;
    logic        st_fault;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    store_rmw_unit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_funct3 (st_funct3),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_done   (st_done),
        .st_fault  (st_fault),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // Word memory and responder
    logic [31:0] mem [bit [29:0]];
    int          rd_wait = 0;
    int          wr_wait = 0;
    int          age = 0;
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    int          wr_count = 0;
    int          done_cnt = 0;
    int          fault_cnt = 0;
    int          both_hi = 0;
    int          addr_bad = 0;
    logic [31:0] exp_addr = '0;
    logic [31:0] last_wr_data = '0;

    function automatic logic [31:0] mem_get(input logic [31:0] a);
        bit [29:0] idx;
        idx = a[31:2];
        return mem.exists(idx) ? mem[idx] : 32'h0;
    endfunction

    always @(negedge clk) begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (st_done)  done_cnt++;
        if (st_fault) fault_cnt++;
        if (mem_rd_en && mem_wr_en) both_hi++;
        if (mem_rd_en || mem_wr_en) begin
            if (mem_addr !== exp_addr) addr_bad++;
            if (mem_rd_en) rd_cycles++; else wr_cycles++;
            if (age >= (mem_rd_en ? rd_wait : wr_wait)) begin
                mem_ack = 1'b1;
                age = 0;
                if (mem_rd_en) begin
                    mem_rdata = mem_get(mem_addr);
                end else begin
                    mem[mem_addr[31:2]] = mem_wdata;
                    last_wr_data = mem_wdata;
                    wr_count++;
                end
            end else begin
                age++;
            end
        end else begin
            age = 0;
        end
    end

    // Reference model: byte-array view of the word
    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [2:0] f3,
                                              input logic [1:0] off, input logic [31:0] d);
        logic [7:0] b [4];
        int o;
        o = int'(off);
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        if (f3 == 3'b000) begin
            b[o] = d[7:0];
        end else if (f3 == 3'b001) begin
            b[o] = d[7:0];
            b[o+1] = d[15:8];
        end else if (f3 == 3'b010) begin
            for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic bit ref_legal(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == 3'b000) return 1'b1;
        if (f3 == 3'b001) return (off % 2) == 0;
        if (f3 == 3'b010) return off == 0;
        return 1'b0;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [1:0] off,
                                       input int rw, input int ww);
        if (!ref_legal(f3, off)) return 2;
        if (f3 == 3'b010) return 3 + ww;
        return 4 + rw + ww;
    endfunction

    // Issues one store; reports outcome, latency and readiness the cycle after.
    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            input int rw, input int ww,
                            output bit got_done, output bit got_fault, output int lat,
                            output bit post_ready);
        got_done = 1'b0;
        got_fault = 1'b0;
        lat = -1;
        post_ready = 1'b0;
        rd_wait = rw;
        wr_wait = ww;
        for (int i = 0; i < 50 && !st_ready; i++) @(negedge clk);
        exp_addr = {a[31:2], 2'b00};
        st_valid = 1'b1;
        st_funct3 = f3;
        st_addr = a;
        st_data = d;
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        st_funct3 = 3'($urandom);
        st_addr = $urandom;
        st_data = $urandom;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (st_done || st_fault) begin
                got_done = st_done;
                got_fault = st_fault;
                lat = c;
                break;
            end
        end
        @(negedge clk);
        post_ready = st_ready && !st_done && !st_fault;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (st_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", st_ready); end
        checks++;
        if ({st_done, st_fault, mem_rd_en, mem_wr_en} !== 4'b0000) begin
            failures++; $display("FAIL reset_pulses got=%b want=0000", {st_done, st_fault, mem_rd_en, mem_wr_en});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            failures++; $display("FAIL reset_mem_regs got=%h/%h want=0/0", mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        bit dn, ft, pr;
        int lat, w0, r0;
        // sb into the top lane
        mem[30'h400] = 32'h11223344;
        w0 = wr_count; r0 = rd_cycles;
        do_store(3'b000, 32'h1003, 32'h000000AB, 0, 0, dn, ft, lat, pr);
        checks++;
        if (!(dn && !ft && lat == 4)) begin failures++; $display("FAIL sb_1003_timing done=%b fault=%b lat=%0d want done lat=4", dn, ft, lat); end
        checks++;
        if (mem[30'h400] !== 32'hAB223344 || wr_count - w0 != 1) begin
            failures++; $display("FAIL sb_1003_word got=%h writes=%0d want=ab223344 writes=1", mem[30'h400], wr_count - w0);
        end
        checks++;
        if (rd_cycles - r0 != 1) begin failures++; $display("FAIL sb_1003_reads got=%0d want=1", rd_cycles - r0); end
        checks++;
        if (!pr) begin failures++; $display("FAIL sb_1003_ready_after got=0 want=1"); end
        // sh upper half
        mem[30'h800] = 32'h11223344;
        do_store(3'b001, 32'h2002, 32'h0000BEEF, 0, 0, dn, ft, lat, pr);
        checks++;
        if (!dn || mem[30'h800] !== 32'hBEEF3344) begin
            failures++; $display("FAIL sh_2002 done=%b got=%h want=beef3344", dn, mem[30'h800]);
        end
        // sb lane 1
        mem[30'h800] = 32'h11223344;
        do_store(3'b000, 32'h2001, 32'h000000CC, 1, 0, dn, ft, lat, pr);
        checks++;
        if (!dn || lat != 5 || mem[30'h800] !== 32'h1122CC44) begin
            failures++; $display("FAIL sb_2001 done=%b lat=%0d got=%h want lat=5 1122cc44", dn, lat, mem[30'h800]);
        end
        // sw with two wait cycles
        w0 = wr_count; r0 = rd_cycles;
        do_store(3'b010, 32'h3000, 32'hDEADBEEF, 0, 2, dn, ft, lat, pr);
        checks++;
        if (!(dn && !ft && lat == 5)) begin failures++; $display("FAIL sw_3000_timing done=%b fault=%b lat=%0d want done lat=5", dn, ft, lat); end
        checks++;
        if (rd_cycles != r0 || wr_count - w0 != 1 || mem[30'hC00] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL sw_3000_mem reads=%0d writes=%0d word=%h want 0/1/deadbeef", rd_cycles - r0, wr_count - w0, mem[30'hC00]);
        end
        // sw zero-wait, next accept in cycle 4
        do_store(3'b010, 32'h3004, 32'h01234567, 0, 0, dn, ft, lat, pr);
        checks++;
        if (!(dn && lat == 3 && pr)) begin failures++; $display("FAIL sw_zero_wait done=%b lat=%0d ready=%b want 1/3/1", dn, lat, pr); end
    endtask

    task automatic test_misaligned();
        bit dn, ft, pr;
        int lat, r0, w0;
        logic [2:0]  f3s [3];
        logic [31:0] as [3];
        f3s[0] = 3'b001; as[0] = 32'h2001;
        f3s[1] = 3'b010; as[1] = 32'h3002;
        f3s[2] = 3'b100; as[2] = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            r0 = rd_cycles; w0 = wr_cycles;
            do_store(f3s[i], as[i], $urandom, 0, 0, dn, ft, lat, pr);
            checks++;
            if (!(ft && !dn && lat == 2 && pr)) begin
                failures++; $display("FAIL bad_req_%0d fault=%b done=%b lat=%0d ready=%b want 1/0/2/1", i, ft, dn, lat, pr);
            end
            checks++;
            if (rd_cycles != r0 || wr_cycles != w0) begin
                failures++; $display("FAIL bad_req_%0d_mem rd=%0d wr=%0d want 0/0", i, rd_cycles - r0, wr_cycles - w0);
            end
        end
    endtask

    task automatic test_timeout();
        bit dn, ft, pr;
        int lat, r0, w0, wc;
        logic [31:0] old;
        // read never acked
        mem[30'h1400] = 32'h5A5A5A5A;
        r0 = rd_cycles; w0 = wr_count; wc = wr_cycles;
        do_store(3'b000, 32'h5001, 32'h77, 100, 0, dn, ft, lat, pr);
        checks++;
        if (!(ft && !dn && lat == 2 + TO)) begin failures++; $display("FAIL rd_timeout fault=%b done=%b lat=%0d want 1/0/%0d", ft, dn, lat, 2 + TO); end
        checks++;
        if (rd_cycles - r0 != TO || wr_count != w0 || wr_cycles != wc) begin
            failures++; $display("FAIL rd_timeout_mem rd=%0d wr=%0d want %0d/0", rd_cycles - r0, wr_cycles - wc, TO);
        end
        checks++;
        if (!pr) begin failures++; $display("FAIL rd_timeout_ready got=0 want=1"); end
        // write never acked
        old = mem_get(32'h5000);
        do_store(3'b010, 32'h5000, 32'hCAFEF00D, 0, 100, dn, ft, lat, pr);
        checks++;
        if (!(ft && lat == 2 + TO) || mem_get(32'h5000) !== old) begin
            failures++; $display("FAIL wr_timeout fault=%b lat=%0d word=%h want 1/%0d/%h", ft, lat, mem_get(32'h5000), 2 + TO, old);
        end
        // ack in the last allowed cycle still wins
        do_store(3'b010, 32'h5000, 32'hCAFEF00D, 0, TO - 1, dn, ft, lat, pr);
        checks++;
        if (!(dn && !ft && lat == 2 + TO) || mem_get(32'h5000) !== 32'hCAFEF00D) begin
            failures++; $display("FAIL ack_at_limit done=%b fault=%b lat=%0d word=%h want 1/0/%0d/cafef00d", dn, ft, lat, mem_get(32'h5000), 2 + TO);
        end
    endtask

    task automatic test_random();
        bit dn, ft, pr;
        int lat, r0, w0, rw, ww, sel, bad;
        logic [2:0]  f3;
        logic [31:0] a, d, old, want;
        bit          ok;
        for (int i = 0; i < 16; i++) mem[30'h2000 + 30'(i)] = $urandom;
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 9) f3 = 3'(sel % 3); else f3 = 3'(3 + $urandom_range(0, 4));
            a = 32'h8000 | ($urandom & 32'h3F);
            d = $urandom;
            rw = $urandom_range(0, TO - 1);
            ww = $urandom_range(0, TO - 1);
            old = mem_get(a);
            ok = ref_legal(f3, a[1:0]);
            want = ok ? ref_store(old, f3, a[1:0], d) : old;
            r0 = rd_cycles; w0 = wr_count;
            do_store(f3, a, d, rw, ww, dn, ft, lat, pr);
            checks++;
            if (dn !== ok || ft !== !ok || lat != ref_latency(f3, a[1:0], rw, ww) || !pr) begin
                failures++; bad++;
                $display("FAIL rand_%0d_ctrl f3=%0d a=%h done=%b fault=%b lat=%0d want lat=%0d legal=%b", n, f3, a, dn, ft, lat, ref_latency(f3, a[1:0], rw, ww), ok);
            end
            checks++;
            if (mem_get(a) !== want || wr_count - w0 != (ok ? 1 : 0) ||
                rd_cycles - r0 != ((ok && f3 != 3'b010) ? rw + 1 : 0)) begin
                failures++; bad++;
                $display("FAIL rand_%0d_data f3=%0d a=%h got=%h want=%h writes=%0d reads=%0d", n, f3, a, mem_get(a), want, wr_count - w0, rd_cycles - r0);
            end
        end
    endtask

    task automatic test_reset_mid();
        int d0, f0, w0;
        bit dn, ft, pr;
        int lat;
        logic [31:0] old;
        mem[30'h1800] = 32'h0BADF00D;
        old = 32'h0BADF00D;
        rd_wait = 0;
        wr_wait = 100;
        exp_addr = 32'h6000;
        for (int i = 0; i < 50 && !st_ready; i++) @(negedge clk);
        st_valid = 1'b1; st_funct3 = 3'b000; st_addr = 32'h6002; st_data = 32'hEE;
        @(posedge clk);
        #1 st_valid = 1'b0;
        for (int i = 0; i < 10 && !mem_wr_en; i++) @(negedge clk);
        checks++;
        if (mem_wr_en !== 1'b1) begin failures++; $display("FAIL rst_mid_reach_write got=%b want=1", mem_wr_en); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_wr_en !== 1'b0 || st_ready !== 1'b1) begin
            failures++; $display("FAIL rst_mid_async wr_en=%b ready=%b want 0/1", mem_wr_en, st_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wr_wait = 0;
        d0 = done_cnt; f0 = fault_cnt; w0 = wr_count;
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (done_cnt != d0 || fault_cnt != f0 || wr_count != w0 || st_ready !== 1'b1 || mem_get(32'h6000) !== old) begin
            failures++; $display("FAIL rst_mid_after done=%0d fault=%0d writes=%0d ready=%b word=%h want 0/0/0/1/%h", done_cnt - d0, fault_cnt - f0, wr_count - w0, st_ready, mem_get(32'h6000), old);
        end
        do_store(3'b000, 32'h6002, 32'hEE, 0, 0, dn, ft, lat, pr);
        checks++;
        if (!dn || lat != 4 || mem_get(32'h6000) !== 32'h0BEEF00D) begin
            failures++; $display("FAIL rst_mid_recover done=%b lat=%0d word=%h want 1/4/0beef00d", dn, lat, mem_get(32'h6000));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_directed();
        test_misaligned();
        test_timeout();
        test_random();
        test_reset_mid();
        checks++;
        if (both_hi != 0) begin failures++; $display("FAIL rd_wr_overlap got=%0d want=0", both_hi); end
        checks++;
        if (addr_bad != 0) begin failures++; $display("FAIL mem_addr_stable got=%0d want=0", addr_bad); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
